sgpio_act_rx: RTL and testbench
===============================

# sgpio_act_rx

Receive-side SGPIO deframer for the status CPLD. It recovers the 36-bit drive-activity vector that the baseboard CPLD serialises on SGPIO_CK/SGPIO_LD/SGPIO_DATA and presents it as a registered parallel bus for the LED drivers. It also supervises the link:
- checks frame length;
- counts framing errors;
- blanks the LEDs when the clock stops.

## Interface
Parameters:
- FRAME_BITS, 36: bits per frame. Legal range 2..64.
- TIMEOUT_CYC, 4096: SYSCLK cycles without a detected SGPIO_CK rise before the link is declared lost. Minimum 16.

Ports:
- SYSCLK  in  1  system clock; all logic is on its rising edge.
- RESET  in  1  synchronous reset, active-high.
- SGPIO_CK  in  1  serial clock from the baseboard CPLD; asynchronous to SYSCLK; frequency ≤ SYSCLK/4.
- SGPIO_LD  in  1  frame marker; high during bit 0 of each frame.
- SGPIO_DATA  in  1  serial data, LSB (drive 0) first.
- ACT_LED  out  FRAME_BITS  last committed activity vector.
- FRAME_VALID  out  1  one-cycle pulse when ACT_LED is updated.
- FRAME_ERR  out  1  one-cycle pulse on a short or long frame.
- LINK_OK  out  1  high once a good frame has been committed; low after reset or timeout.
- ERR_CNT  out  8  count of framing errors; saturates at 255.

## Operation
- **Synchronisation.** CK, LD and DATA each pass through an identical 2-FF synchroniser. A third CK register provides edge detect. `ck_rise` = sync CK high and previous sync CK low. LD and DATA are sampled from the synchronised stage in the `ck_rise` cycle.
- **State machine.** States are HUNT, SHIFT and EXPECT_LD. All transitions occur only on `ck_rise`, except timeout.
  - HUNT, LD=1: load DATA into shift bit 0, set `bitcnt`=1, go to SHIFT.
  - HUNT, LD=0: ignore; no error.
  - SHIFT, LD=0: store DATA at shift[`bitcnt`] and increment `bitcnt`.
    - If the stored bit was bit FRAME_BITS-1: commit, i.e. ACT_LED ← shift register including this bit, FRAME_VALID=1, LINK_OK=1. Then go to EXPECT_LD.
  - SHIFT, LD=1 (short frame): pulse FRAME_ERR, increment ERR_CNT. Discard the partial frame and treat this bit as bit 0 of a new frame (`bitcnt`=1). Stay in SHIFT.
  - EXPECT_LD, LD=1: capture bit 0 of a new frame, go to SHIFT.
  - EXPECT_LD, LD=0 (long frame): pulse FRAME_ERR, increment ERR_CNT, go to HUNT.
- **Shift register.** Bits not yet written in the current frame are don't-care. ACT_LED changes only on commit or timeout.
- **Timeout.** `idle_cnt` clears on every `ck_rise` and otherwise increments, saturating at TIMEOUT_CYC. When it reaches TIMEOUT_CYC-1 → TIMEOUT_CYC:
  - ACT_LED ← 0 and LINK_OK ← 0;
  - state ← HUNT, `bitcnt` ← 0;
  - no FRAME_ERR and no ERR_CNT change.

  Timeout fires once per idle period.
- **ERR_CNT** increments by 1 per FRAME_ERR pulse and holds at 255.
- **Reset values.** All of the following are 0: ACT_LED, FRAME_VALID, FRAME_ERR, LINK_OK, ERR_CNT, synchroniser flops, `bitcnt`, `idle_cnt`. State is HUNT. RESET takes precedence over every other event, including mid-frame: the partial frame is lost and the next frame must start with LD.

## Timing
- A pin edge on SGPIO_CK is seen as `ck_rise` 3 SYSCLK edges later (2 sync + 1 edge register). LD and DATA must be stable for ≥1 SYSCLK around the CK rise; DATA changes on the CK falling edge.
- Commit latency: ACT_LED and FRAME_VALID assert on the SYSCLK edge after the `ck_rise` cycle of bit FRAME_BITS-1. Worst case is 4 SYSCLK edges after the pin edge.
- FRAME_ERR and ERR_CNT update at the same latency, on the offending `ck_rise`.
- If `ck_rise` and the idle count reaching TIMEOUT_CYC fall in the same cycle, `ck_rise` wins: no timeout, and the bit is processed.
- FRAME_VALID and FRAME_ERR are never high in the same cycle.
- Back-to-back frames with continuous CK commit every FRAME_BITS CK periods; no gap bit is required.

## Test plan
- **Back-to-back frames.** Reset, then send frames 36'hB_0000_0005, 36'hB_110A_0005, 36'hB_110A_4265, 36'hF_FFFF_FFFF, 36'h0_0000_0000, each repeated 3 times. Required: ACT_LED equals each value after that value's first frame; FRAME_VALID pulses 15 times; ERR_CNT=0; LINK_OK=1 from the first commit.
- **Short frame.** Raise LD after 20 bits, then send a full 36'h1_2345_6789 frame. Required: one FRAME_ERR; ERR_CNT=1; ACT_LED keeps its prior value until it becomes 36'h1_2345_6789.
- **Long frame.** Send 37 bits with LD only on bit 0. Required: commit on bit 35; FRAME_ERR on bit 36; ERR_CNT increments. The next LD-marked frame commits normally.
- **Timeout.** After ACT_LED=36'hF_FFFF_FFFF, stop CK for TIMEOUT_CYC+10 cycles. Required: ACT_LED=0 and LINK_OK=0 exactly TIMEOUT_CYC cycles after the last `ck_rise`; no FRAME_ERR. A new frame restores LINK_OK=1.
- **Reset mid-frame and startup alignment.** Assert RESET at bit 17. Required: all outputs 0 on the next edge. Bits before the next LD are ignored without error, and the following frame commits.
- **ERR_CNT saturation.** Inject 300 short frames. Required: ERR_CNT stops at 255.

Source files
------------

// File: rtl/sgpio_act_rx.sv
// sgpio_act_rx: receive-side SGPIO deframer.
// Recovers the FRAME_BITS-wide drive-activity vector serialised on
// SGPIO_CK/SGPIO_LD/SGPIO_DATA (LSB first, LD marks bit 0) and presents it
// as a registered parallel bus. Supervises the link: frame-length checks,
// a saturating framing-error counter and LED blanking on clock loss.
//
// Ports:
//   SYSCLK       system clock, all logic on its rising edge
//   RESET        synchronous reset, active-high
//   SGPIO_CK     serial clock (asynchronous, <= SYSCLK/4)
//   SGPIO_LD     frame marker, high during bit 0
//   SGPIO_DATA   serial data, drive 0 first
//   ACT_LED      last committed activity vector
//   FRAME_VALID  one-cycle pulse when ACT_LED is updated by a frame
//   FRAME_ERR    one-cycle pulse on a short or long frame
//   LINK_OK      high once a good frame is committed, low after reset/timeout
//   ERR_CNT      framing error count, saturating at 255
module sgpio_act_rx #(
    parameter int unsigned FRAME_BITS  = 36,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                  SYSCLK,
    input  logic                  RESET,
    input  logic                  SGPIO_CK,
    input  logic                  SGPIO_LD,
    input  logic                  SGPIO_DATA,
    output logic [FRAME_BITS-1:0] ACT_LED,
    output logic                  FRAME_VALID,
    output logic                  FRAME_ERR,
    output logic                  LINK_OK,
    output logic [7:0]            ERR_CNT
);

    localparam int unsigned IW  = $clog2(FRAME_BITS);
    localparam int unsigned IDW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_HUNT      = 2'd0,
        ST_SHIFT     = 2'd1,
        ST_EXPECT_LD = 2'd2
    } state_e;

    // Synchroniser and edge-detect flops
    logic ck_meta_q, ck_sync_q, ck_prev_q;
    logic ld_meta_q, ld_sync_q;
    logic dat_meta_q, dat_sync_q;

    state_e                state_q, state_d;
    logic [IW-1:0]         bitcnt_q, bitcnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [IDW-1:0]        idle_q, idle_d;
    logic [FRAME_BITS-1:0] act_led_q, act_led_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  link_ok_q, link_ok_d;
    logic [7:0]            err_cnt_q, err_cnt_d;

    logic ck_rise_c;
    logic err_inc_c;

    assign ck_rise_c = ck_sync_q & ~ck_prev_q;

    // Idle counter: cleared by every CK rise, saturates at TIMEOUT_CYC
    always_comb begin
        idle_d = idle_q;
        if (ck_rise_c) begin
            idle_d = '0;
        end else if (idle_q != IDW'(TIMEOUT_CYC)) begin
            idle_d = idle_q + IDW'(1);
        end
    end

    // Deframer state machine and output next-state logic
    always_comb begin
        state_d       = state_q;
        bitcnt_d      = bitcnt_q;
        shift_d       = shift_q;
        act_led_d     = act_led_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        link_ok_d     = link_ok_q;
        err_cnt_d     = err_cnt_q;
        err_inc_c     = 1'b0;

        if (ck_rise_c) begin
            // A CK rise always beats a coincident timeout
            case (state_q)
                ST_HUNT: begin
                    if (ld_sync_q) begin
                        shift_d[0] = dat_sync_q;
                        bitcnt_d   = IW'(1);
                        state_d    = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (ld_sync_q) begin
                        // Short frame: restart with this bit as bit 0
                        err_inc_c   = 1'b1;
                        frame_err_d = 1'b1;
                        shift_d[0]  = dat_sync_q;
                        bitcnt_d    = IW'(1);
                    end else begin
                        shift_d[bitcnt_q] = dat_sync_q;
                        if (bitcnt_q == IW'(FRAME_BITS - 1)) begin
                            act_led_d     = shift_d;
                            frame_valid_d = 1'b1;
                            link_ok_d     = 1'b1;
                            bitcnt_d      = '0;
                            state_d       = ST_EXPECT_LD;
                        end else begin
                            bitcnt_d = bitcnt_q + IW'(1);
                        end
                    end
                end
                ST_EXPECT_LD: begin
                    if (ld_sync_q) begin
                        shift_d[0] = dat_sync_q;
                        bitcnt_d   = IW'(1);
                        state_d    = ST_SHIFT;
                    end else begin
                        // Long frame: drop back and wait for the next LD
                        err_inc_c   = 1'b1;
                        frame_err_d = 1'b1;
                        bitcnt_d    = '0;
                        state_d     = ST_HUNT;
                    end
                end
                default: begin
                    bitcnt_d = '0;
                    state_d  = ST_HUNT;
                end
            endcase
        end else if (idle_q == IDW'(TIMEOUT_CYC - 1)) begin
            // Link lost: fires only on the step into saturation
            act_led_d = '0;
            link_ok_d = 1'b0;
            bitcnt_d  = '0;
            state_d   = ST_HUNT;
        end

        if (err_inc_c && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // State and output registers
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            ck_meta_q     <= 1'b0;
            ck_sync_q     <= 1'b0;
            ck_prev_q     <= 1'b0;
            ld_meta_q     <= 1'b0;
            ld_sync_q     <= 1'b0;
            dat_meta_q    <= 1'b0;
            dat_sync_q    <= 1'b0;
            state_q       <= ST_HUNT;
            bitcnt_q      <= '0;
            shift_q       <= '0;
            idle_q        <= '0;
            act_led_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            link_ok_q     <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            ck_meta_q     <= SGPIO_CK;
            ck_sync_q     <= ck_meta_q;
            ck_prev_q     <= ck_sync_q;
            ld_meta_q     <= SGPIO_LD;
            ld_sync_q     <= ld_meta_q;
            dat_meta_q    <= SGPIO_DATA;
            dat_sync_q    <= dat_meta_q;
            state_q       <= state_d;
            bitcnt_q      <= bitcnt_d;
            shift_q       <= shift_d;
            idle_q        <= idle_d;
            act_led_q     <= act_led_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            link_ok_q     <= link_ok_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign ACT_LED     = act_led_q;
    assign FRAME_VALID = frame_valid_q;
    assign FRAME_ERR   = frame_err_q;
    assign LINK_OK     = link_ok_q;
    assign ERR_CNT     = err_cnt_q;

endmodule

// File: tb/tb_sgpio_act_rx.sv
// Bench for sgpio_act_rx: table of frames with hand-computed results, plus
// directed sequences for timeout, mid-frame reset and ERR_CNT saturation.
module tb_sgpio_act_rx;

    localparam int unsigned FB = 36;
    localparam int unsigned TO = 64;

    logic          SYSCLK = 1'b0;
    logic          RESET;
    logic          SGPIO_CK;
    logic          SGPIO_LD;
    logic          SGPIO_DATA;
    logic [FB-1:0] ACT_LED;
    logic          FRAME_VALID;
    logic          FRAME_ERR;
    logic          LINK_OK;
    logic [7:0]    ERR_CNT;

    sgpio_act_rx #(.FRAME_BITS(FB), .TIMEOUT_CYC(TO)) dut (
        .SYSCLK     (SYSCLK),
        .RESET      (RESET),
        .SGPIO_CK   (SGPIO_CK),
        .SGPIO_LD   (SGPIO_LD),
        .SGPIO_DATA (SGPIO_DATA),
        .ACT_LED    (ACT_LED),
        .FRAME_VALID(FRAME_VALID),
        .FRAME_ERR  (FRAME_ERR),
        .LINK_OK    (LINK_OK),
        .ERR_CNT    (ERR_CNT)
    );

    always #5 SYSCLK = ~SYSCLK;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int fv_cnt   = 0;
    int fe_cnt   = 0;
    int both_hi  = 0;
    int fv_cyc   = 0;

    always @(posedge SYSCLK) cyc <= cyc + 1;

    // Pulse monitor, sampled away from the active edge
    always @(negedge SYSCLK) begin
        if (FRAME_VALID) begin
            fv_cnt = fv_cnt + 1;
            fv_cyc = cyc;
        end
        if (FRAME_ERR) fe_cnt = fe_cnt + 1;
        if (FRAME_VALID && FRAME_ERR) both_hi = both_hi + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One SGPIO bit: data set while CK low, CK rises, held across the rise
    task automatic send_bit(input logic ld, input logic d);
        @(negedge SYSCLK);
        SGPIO_CK   = 1'b0;
        SGPIO_LD   = ld;
        SGPIO_DATA = d;
        repeat (4) @(negedge SYSCLK);
        SGPIO_CK = 1'b1;
        repeat (4) @(negedge SYSCLK);
    endtask

    // LD on bit 0 only; bits beyond FB are sent as 1
    task automatic send_frame(input logic [FB-1:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(i == 0, (i < FB) ? v[i] : 1'b1);
        end
    endtask

    typedef struct {
        int          kind;   // 0 full, 1 short (20 bits), 2 long (37 bits)
        logic [35:0] val;
        logic [35:0] exp_act;
        int          exp_err;
        int          exp_fv;
        int          exp_fe;
    } vec_t;

    vec_t        tbl[20];
    logic [35:0] vals[5];

    initial begin
        int fe0;
        int zcyc;
        bit seen;

        vals[0] = 36'hB_0000_0005;
        vals[1] = 36'hB_110A_0005;
        vals[2] = 36'hB_110A_4265;
        vals[3] = 36'hF_FFFF_FFFF;
        vals[4] = 36'h0_0000_0000;
        for (int i = 0; i < 15; i++) begin
            tbl[i] = '{0, vals[i/3], vals[i/3], 0, i + 1, 0};
        end
        tbl[15] = '{1, 36'h0_DEAD_BEEF, 36'h0_0000_0000, 0, 15, 0};
        tbl[16] = '{0, 36'h1_2345_6789, 36'h1_2345_6789, 1, 16, 1};
        tbl[17] = '{2, 36'hA_BCDE_F012, 36'hA_BCDE_F012, 2, 17, 2};
        tbl[18] = '{0, 36'h3_0C0C_0C0C, 36'h3_0C0C_0C0C, 2, 18, 2};
        tbl[19] = '{0, 36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, 2, 19, 2};

        RESET      = 1'b1;
        SGPIO_CK   = 1'b0;
        SGPIO_LD   = 1'b0;
        SGPIO_DATA = 1'b0;
        repeat (3) @(negedge SYSCLK);
        RESET = 1'b0;
        @(negedge SYSCLK);
        chk("reset_act", 64'(ACT_LED), 64'h0);
        chk("reset_fv", 64'(FRAME_VALID), 64'h0);
        chk("reset_fe", 64'(FRAME_ERR), 64'h0);
        chk("reset_link", 64'(LINK_OK), 64'h0);
        chk("reset_errcnt", 64'(ERR_CNT), 64'h0);

        // Table: back-to-back, short and long frames
        for (int i = 0; i < 20; i++) begin
            case (tbl[i].kind)
                1:       send_frame(tbl[i].val, 20);
                2:       send_frame(tbl[i].val, 37);
                default: send_frame(tbl[i].val, 36);
            endcase
            chk($sformatf("tbl%0d_act", i), 64'(ACT_LED), 64'(tbl[i].exp_act));
            chk($sformatf("tbl%0d_errcnt", i), 64'(ERR_CNT), 64'(tbl[i].exp_err));
            chk($sformatf("tbl%0d_fvcnt", i), 64'(fv_cnt), 64'(tbl[i].exp_fv));
            chk($sformatf("tbl%0d_fecnt", i), 64'(fe_cnt), 64'(tbl[i].exp_fe));
            chk($sformatf("tbl%0d_link", i), 64'(LINK_OK), 64'h1);
        end

        // Timeout: CK stops after the all-ones commit
        fe0  = fe_cnt;
        seen = 1'b0;
        zcyc = 0;
        SGPIO_CK = 1'b0;
        for (int k = 0; k < int'(TO) + 10; k++) begin
            @(negedge SYSCLK);
            if (!seen && ACT_LED == '0) begin
                seen = 1'b1;
                zcyc = cyc;
            end
        end
        chk("to_seen", 64'(seen), 64'h1);
        chk("to_latency", 64'(zcyc - fv_cyc), 64'(TO));
        chk("to_link", 64'(LINK_OK), 64'h0);
        chk("to_act", 64'(ACT_LED), 64'h0);
        chk("to_fe", 64'(fe_cnt - fe0), 64'h0);
        chk("to_errcnt", 64'(ERR_CNT), 64'h2);
        send_frame(36'h5_5555_AAAA, 36);
        chk("to_rec_link", 64'(LINK_OK), 64'h1);
        chk("to_rec_act", 64'(ACT_LED), 64'h5_5555_AAAA);

        // Reset at bit 17 of a frame
        send_frame(36'h7_7777_7777, 17);
        @(negedge SYSCLK);
        SGPIO_CK = 1'b0;
        repeat (4) @(negedge SYSCLK);
        RESET = 1'b1;
        @(negedge SYSCLK);
        chk("mrst_act", 64'(ACT_LED), 64'h0);
        chk("mrst_fv", 64'(FRAME_VALID), 64'h0);
        chk("mrst_fe", 64'(FRAME_ERR), 64'h0);
        chk("mrst_link", 64'(LINK_OK), 64'h0);
        chk("mrst_errcnt", 64'(ERR_CNT), 64'h0);
        RESET = 1'b0;
        fe0 = fe_cnt;
        for (int i = 0; i < 10; i++) send_bit(1'b0, 1'b1);
        chk("align_act", 64'(ACT_LED), 64'h0);
        chk("align_link", 64'(LINK_OK), 64'h0);
        chk("align_fe", 64'(fe_cnt - fe0), 64'h0);
        send_frame(36'h8_4210_8421, 36);
        chk("align_commit", 64'(ACT_LED), 64'h8_4210_8421);
        chk("align_link2", 64'(LINK_OK), 64'h1);
        chk("align_errcnt", 64'(ERR_CNT), 64'h0);

        // ERR_CNT saturation: 300 two-bit short frames
        fe0 = fe_cnt;
        send_bit(1'b1, 1'b0);
        for (int i = 1; i <= 300; i++) begin
            send_bit(1'b0, 1'b1);
            send_bit(1'b1, 1'b0);
            if (i == 254) chk("sat_254", 64'(ERR_CNT), 64'd254);
            if (i == 255) chk("sat_255", 64'(ERR_CNT), 64'd255);
        end
        chk("sat_final", 64'(ERR_CNT), 64'd255);
        chk("sat_fe_pulses", 64'(fe_cnt - fe0), 64'd300);
        chk("sat_act_hold", 64'(ACT_LED), 64'h8_4210_8421);

        chk("fv_fe_exclusive", 64'(both_hi), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
